// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB-first, even parity, one stop bit, with an
// internal 16x baud generator whose divisor is latched when a write is accepted.
module uart_transmitter #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  output logic       TxD,
  output logic       Tx_BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int MAX_DIV = (CLK_HZ + (OVERSAMPLE * 300) / 2) / (OVERSAMPLE * 300);
  localparam int DIV_W   = $clog2(MAX_DIV + 1);
  localparam int OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  // Divisor rounded to nearest: round(CLK_HZ / (OVERSAMPLE * baud)).
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code);
    int baud;
    case (code)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return DIV_W'((CLK_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud));
  endfunction

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [OS_W-1:0]  os_cnt_reg, os_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic             txd_reg, txd_next;
  logic             busy_reg, busy_next;
  logic             baud_tick;
  logic             bit_done;

  assign baud_tick = (baud_cnt_reg == div_reg - DIV_W'(1));
  assign bit_done  = baud_tick && (os_cnt_reg == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    baud_cnt_next = baud_cnt_reg;
    os_cnt_next   = os_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    txd_next      = txd_reg;

    if (state_reg == IDLE) begin
      baud_cnt_next = '0;
      os_cnt_next   = '0;
      bit_cnt_next  = '0;
      txd_next      = 1'b1;
      if (Tx_EN && Tx_WR) begin
        shift_next  = Tx_DATA;
        parity_next = ^Tx_DATA;
        div_next    = baud_div(baud_select);
        state_next  = START;
        txd_next    = 1'b0;
      end
    end else if (!Tx_EN) begin
      // Disabling the transmitter abandons the frame on the next edge.
      state_next    = IDLE;
      txd_next      = 1'b1;
      baud_cnt_next = '0;
      os_cnt_next   = '0;
      bit_cnt_next  = '0;
    end else begin
      baud_cnt_next = baud_tick ? '0 : baud_cnt_reg + DIV_W'(1);
      if (baud_tick)
        os_cnt_next = bit_done ? '0 : os_cnt_reg + OS_W'(1);
      if (bit_done) begin
        case (state_reg)
          START: begin
            state_next   = DATA;
            bit_cnt_next = '0;
            txd_next     = shift_reg[0];
          end
          DATA: begin
            if (bit_cnt_reg == 3'd7) begin
              state_next = PARITY;
              txd_next   = parity_reg;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
              shift_next   = shift_reg >> 1;
              txd_next     = shift_reg[1];
            end
          end
          PARITY: begin
            state_next = STOP;
            txd_next   = 1'b1;
          end
          default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
          end
        endcase
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      baud_cnt_reg <= '0;
      os_cnt_reg   <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      baud_cnt_reg <= baud_cnt_next;
      os_cnt_reg   <= os_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
    end
  end

  assign TxD     = txd_reg;
  assign Tx_BUSY = busy_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: expected frame bits are queued when a
// write is issued and checked bit-window by bit-window as the line toggles.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       Tx_WR;
  logic       Tx_EN;
  logic       TxD;
  logic       Tx_BUSY;

  int checks   = 0;
  int failures = 0;

  logic exp_q[$];
  int   len_q[$];
  int   cur_len;
  int   frame_left;
  int   bit_idx;
  int   frame_no = 0;
  int   div_tab[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  uart_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .Tx_DATA    (Tx_DATA),
    .baud_select(baud_select),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s frame=%0d observed=%b expected=%b", tag, frame_no, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s frame=%0d observed=%0d expected=%0d", tag, frame_no, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [2:0] code);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(^d);
    exp_q.push_back(1'b1);
    len_q.push_back(16 * div_tab[code]);
  endtask

  // Raise Tx_WR at a negedge; the frame's first cycle is the next negedge.
  task automatic start_write(input logic [7:0] d, input logic [2:0] code);
    @(negedge clk);
    Tx_DATA     = d;
    baud_select = code;
    Tx_WR       = 1'b1;
    push_frame(d, code);
  endtask

  task automatic wait_busy_rise(input int exp_lat);
    int lat;
    lat = 0;
    frame_no++;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (Tx_BUSY === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk_int("busy_latency", lat, exp_lat);
    chk("first_cycle_txd", TxD, 1'b0);
    cur_len    = len_q.pop_front();
    frame_left = 11;
    bit_idx    = 0;
  endtask

  // Checks the first and last cycle of each of the next n bit windows.
  task automatic check_bits(input int n);
    logic b;
    for (int k = 0; k < n; k++) begin
      b = exp_q.pop_front();
      frame_left--;
      chk($sformatf("bit%0d_first", bit_idx), TxD, b);
      repeat (cur_len - 1) @(negedge clk);
      chk($sformatf("bit%0d_last", bit_idx), TxD, b);
      chk($sformatf("bit%0d_busy", bit_idx), Tx_BUSY, 1'b1);
      @(negedge clk);
      bit_idx++;
    end
  endtask

  task automatic flush_frame();
    while (frame_left > 0) begin
      void'(exp_q.pop_front());
      frame_left--;
    end
  endtask

  task automatic end_frame();
    chk("end_busy", Tx_BUSY, 1'b0);
    chk("end_txd", TxD, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'b000;

    #50;
    chk("reset_txd", TxD, 1'b1);
    chk("reset_busy", Tx_BUSY, 1'b0);
    #50 reset = 1'b0;

    // Disabled transmitter ignores writes.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      Tx_WR = (i % 3 != 2);
      chk("disabled_txd", TxD, 1'b1);
      chk("disabled_busy", Tx_BUSY, 1'b0);
    end
    Tx_WR = 1'b0;
    repeat (2) @(negedge clk);
    chk("disabled_txd_end", TxD, 1'b1);
    Tx_EN = 1'b1;

    // Frame 1: 0xA5 at 115200; a mid-frame write with new data is ignored.
    start_write(8'hA5, 3'b111);
    wait_busy_rise(1);
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h5A;
    baud_select = 3'b000;
    fork
      check_bits(11);
      begin
        repeat (1000) @(negedge clk);
        Tx_WR   = 1'b1;
        Tx_DATA = 8'hFF;
        repeat (3) @(negedge clk);
        Tx_WR   = 1'b0;
      end
    join
    end_frame();

    // Frames 2 and 3: Tx_WR held high, second frame starts right after busy falls.
    start_write(8'h3C, 3'b111);
    wait_busy_rise(1);
    check_bits(11);
    end_frame();
    push_frame(8'h3C, 3'b111);
    wait_busy_rise(1);
    Tx_WR = 1'b0;
    check_bits(9);
    // Now inside the parity bit: dropping Tx_EN aborts on the next edge.
    repeat (5) @(negedge clk);
    chk("parity_busy_before_abort", Tx_BUSY, 1'b1);
    Tx_EN = 1'b0;
    @(posedge clk);
    #1;
    chk("en_abort_txd", TxD, 1'b1);
    chk("en_abort_busy", Tx_BUSY, 1'b0);
    flush_frame();
    repeat (4) @(negedge clk);
    Tx_EN = 1'b1;

    // Frame 4: asynchronous reset during data bit 3.
    start_write(8'hC3, 3'b111);
    wait_busy_rise(1);
    Tx_WR = 1'b0;
    check_bits(4);
    repeat (50) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_txd", TxD, 1'b1);
    chk("async_reset_busy", Tx_BUSY, 1'b0);
    flush_frame();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Frame 5: clean frame after reset.
    start_write(8'h96, 3'b111);
    wait_busy_rise(1);
    Tx_WR = 1'b0;
    check_bits(11);
    end_frame();

    // Frame 6: 0x01 at 9600 -> parity 1, 5216 clocks per bit.
    start_write(8'h01, 3'b011);
    wait_busy_rise(1);
    Tx_WR = 1'b0;
    check_bits(11);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
